// File: rtl/mod_n_cascade_counter_pkg.sv
// Shared constants and helpers for the cascaded modulo-N counter.
package counter_pkg;

    localparam int BCD_MODULUS = 10;

    // Digit width for a given modulus, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mod_n_cascade_counter_if.sv
// Count/load/status bundle between the pulse-conditioning side and the counter.
interface mod_n_cascade_counter_if #(parameter int CNT_W = 8);

    logic             iEnable;
    logic             iUp;
    logic             iLoad;
    logic [CNT_W-1:0] ivLoadValue;
    logic [CNT_W-1:0] ovCount;
    logic             oTick;
    logic             oOverflow;

    modport master (
        output iEnable, iUp, iLoad, ivLoadValue,
        input  ovCount, oTick, oOverflow
    );

    modport slave (
        input  iEnable, iUp, iLoad, ivLoadValue,
        output ovCount, oTick, oOverflow
    );

endinterface

// File: rtl/mod_n_cascade_counter_digit.sv
// One modulo-N digit: load with coercion, up/down step with wrap, illegal-value scrub.
module mod_n_digit #(
    parameter int MODULUS = 10,
    parameter int DIGIT_W = 4
) (
    input  logic               iclk,
    input  logic               iReset,
    input  logic               iLoad,
    input  logic [DIGIT_W-1:0] ivLoadDigit,
    input  logic               iStep,
    input  logic               iUp,
    output logic [DIGIT_W-1:0] ovDigit,
    output logic               oAtMax,
    output logic               oAtZero
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               illegal;

    // An illegal digit is neither at max nor zero, so it can never feed a carry.
    assign illegal = (int'(digit_q) >= MODULUS);
    assign oAtMax  = (digit_q == MAX_V);
    assign oAtZero = (digit_q == '0);
    assign ovDigit = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (iLoad) begin
            digit_d = (int'(ivLoadDigit) >= MODULUS) ? '0 : ivLoadDigit;
        end else if (illegal) begin
            digit_d = '0;
        end else if (iStep) begin
            if (iUp) digit_d = oAtMax  ? '0    : digit_q + DIGIT_W'(1);
            else     digit_d = oAtZero ? MAX_V : digit_q - DIGIT_W'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (iReset) digit_q <= '0;
        else        digit_q <= digit_d;
    end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Multi-digit modulo-N up/down counter with terminal tick and optional saturation.
module mod_n_cascade_counter
    import counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int MODULUS  = BCD_MODULUS,
    parameter int SATURATE = 0
) (
    input  logic                    iclk,
    input  logic                    iReset,
    mod_n_cascade_counter_if.slave  bus
);

    localparam int DIGIT_W = clog2_min1(MODULUS);
    localparam int CNT_W   = DIGITS * DIGIT_W;
    localparam bit SAT     = (SATURATE != 0);

    logic [DIGITS-1:0] at_max, at_zero;
    logic [DIGITS:0]   chain_up, chain_dn;
    logic [CNT_W-1:0]  count;
    logic              term, step_req, hit, step_ok;
    logic              tick_q, tick_d, ovf_q, ovf_d;

    assign chain_up[0] = 1'b1;
    assign chain_dn[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic step_k;
        assign chain_up[k+1] = chain_up[k] & at_max[k];
        assign chain_dn[k+1] = chain_dn[k] & at_zero[k];
        assign step_k = step_ok & (bus.iUp ? chain_up[k] : chain_dn[k]);

        mod_n_digit #(.MODULUS(MODULUS), .DIGIT_W(DIGIT_W)) u_digit (
            .iclk        (iclk),
            .iReset      (iReset),
            .iLoad       (bus.iLoad),
            .ivLoadDigit (bus.ivLoadValue[k*DIGIT_W +: DIGIT_W]),
            .iStep       (step_k),
            .iUp         (bus.iUp),
            .ovDigit     (count[k*DIGIT_W +: DIGIT_W]),
            .oAtMax      (at_max[k]),
            .oAtZero     (at_zero[k])
        );
    end

    // Terminal is the full AND-chain in the requested direction.
    assign term     = bus.iUp ? chain_up[DIGITS] : chain_dn[DIGITS];
    assign step_req = bus.iEnable & ~bus.iLoad;
    assign hit      = step_req & term;
    assign step_ok  = step_req & ~(SAT & term);

    always_comb begin
        tick_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.iLoad) begin
            ovf_d = 1'b0;
        end else if (hit) begin
            // In saturate mode only the first terminal enable ticks.
            tick_d = SAT ? ~ovf_q : 1'b1;
            if (SAT) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge iclk) begin
        if (iReset) begin
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tick_q <= tick_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.ovCount   = count;
    assign bus.oTick     = tick_q;
    assign bus.oOverflow = ovf_q;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Directed bench: 2-digit BCD counter, one wrapping and one saturating instance.
module tb_mod_n_cascade_counter;

    logic iclk;
    logic iReset;
    int   n_cmp;
    int   n_err;

    mod_n_cascade_counter_if #(.CNT_W(8)) bus_w ();
    mod_n_cascade_counter_if #(.CNT_W(8)) bus_s ();

    mod_n_cascade_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) u_wrap (
        .iclk   (iclk),
        .iReset (iReset),
        .bus    (bus_w)
    );

    mod_n_cascade_counter #(.DIGITS(2), .MODULUS(10), .SATURATE(1)) u_sat (
        .iclk   (iclk),
        .iReset (iReset),
        .bus    (bus_s)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus to both counters, then return to idle just after the edge.
    task automatic apply(input logic r, input logic l, input logic e, input logic u,
                         input logic [7:0] v);
        iReset            = r;
        bus_w.iLoad       = l;  bus_s.iLoad       = l;
        bus_w.iEnable     = e;  bus_s.iEnable     = e;
        bus_w.iUp         = u;  bus_s.iUp         = u;
        bus_w.ivLoadValue = v;  bus_s.ivLoadValue = v;
        @(posedge iclk);
        #1;
        iReset        = 1'b0;
        bus_w.iLoad   = 1'b0;  bus_s.iLoad   = 1'b0;
        bus_w.iEnable = 1'b0;  bus_s.iEnable = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        apply(1'b0, 1'b1, 1'b0, 1'b0, v);
    endtask

    task automatic en(input logic u);
        apply(1'b0, 1'b0, 1'b1, u, 8'h00);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        iReset = 1'b0;
        bus_w.iLoad = 1'b0; bus_w.iEnable = 1'b0; bus_w.iUp = 1'b0; bus_w.ivLoadValue = '0;
        bus_s.iLoad = 1'b0; bus_s.iEnable = 1'b0; bus_s.iUp = 1'b0; bus_s.ivLoadValue = '0;
        @(negedge iclk);

        // Reset and count up five
        apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("rst_count", bus_w.ovCount, 8'h00);
        check_eq("rst_tick", bus_w.oTick, 1'b0);
        check_eq("rst_ovf", bus_s.oOverflow, 1'b0);
        for (int i = 0; i < 5; i++) begin
            en(1'b1);
            check_eq("up5_tick", bus_w.oTick, 1'b0);
        end
        check_eq("up5_count", bus_w.ovCount, 8'h05);
        check_eq("up5_count_sat", bus_s.ovCount, 8'h05);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("idle_hold", bus_w.ovCount, 8'h05);

        // Up wrap
        load(8'h98);
        check_eq("ld98", bus_w.ovCount, 8'h98);
        en(1'b1);
        check_eq("up99", bus_w.ovCount, 8'h99);
        check_eq("up99_tick", bus_w.oTick, 1'b0);
        en(1'b1);
        check_eq("wrap00", bus_w.ovCount, 8'h00);
        check_eq("wrap00_tick", bus_w.oTick, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("wrap_tick_clr", bus_w.oTick, 1'b0);

        // Carry and borrow across the digit boundary
        load(8'h39);
        en(1'b1);
        check_eq("carry40", bus_w.ovCount, 8'h40);
        en(1'b0);
        check_eq("borrow39", bus_w.ovCount, 8'h39);

        // Down steps and down wrap
        load(8'h10);
        en(1'b0);
        check_eq("dn09", bus_w.ovCount, 8'h09);
        check_eq("dn09_tick", bus_w.oTick, 1'b0);
        load(8'h00);
        en(1'b0);
        check_eq("dnwrap99", bus_w.ovCount, 8'h99);
        check_eq("dnwrap_tick", bus_w.oTick, 1'b1);

        // Saturating instance at up terminal
        load(8'h99);
        check_eq("sat_ld_ovf", bus_s.oOverflow, 1'b0);
        en(1'b1);
        check_eq("sat1_count", bus_s.ovCount, 8'h99);
        check_eq("sat1_tick", bus_s.oTick, 1'b1);
        check_eq("sat1_ovf", bus_s.oOverflow, 1'b1);
        en(1'b1);
        check_eq("sat2_count", bus_s.ovCount, 8'h99);
        check_eq("sat2_tick", bus_s.oTick, 1'b0);
        en(1'b1);
        check_eq("sat3_tick", bus_s.oTick, 1'b0);
        check_eq("sat3_ovf", bus_s.oOverflow, 1'b1);
        load(8'h12);
        check_eq("sat_ld_clr_ovf", bus_s.oOverflow, 1'b0);
        check_eq("sat_ld12", bus_s.ovCount, 8'h12);
        en(1'b1);
        check_eq("sat_up13", bus_s.ovCount, 8'h13);
        check_eq("sat_up13_ovf", bus_s.oOverflow, 1'b0);

        // Saturating instance at down terminal
        load(8'h00);
        en(1'b0);
        check_eq("satdn_count", bus_s.ovCount, 8'h00);
        check_eq("satdn_tick", bus_s.oTick, 1'b1);
        check_eq("satdn_ovf", bus_s.oOverflow, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("satdn_rst_ovf", bus_s.oOverflow, 1'b0);

        // Load coercion of out-of-range digits
        load(8'hA3);
        check_eq("ldA3", bus_w.ovCount, 8'h03);
        load(8'hFF);
        check_eq("ldFF", bus_w.ovCount, 8'h00);
        load(8'h3C);
        check_eq("ld3C", bus_w.ovCount, 8'h30);

        // Priority: reset over load over enable
        load(8'h57);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        check_eq("prio_rst", bus_w.ovCount, 8'h00);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'h42);
        check_eq("prio_ld", bus_w.ovCount, 8'h42);
        check_eq("prio_ld_tick", bus_w.oTick, 1'b0);
        load(8'h99);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 8'h99);
        check_eq("ld_at_term_tick", bus_w.oTick, 1'b0);
        check_eq("ld_at_term_count", bus_w.ovCount, 8'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
